// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
// One bit leaves the BCD digits per cycle; digits >= 8 are corrected by -3 after every shift.
module bcd_to_bin #(
   parameter int DIGITS = 4,
   parameter int DEC_4  = 4,
   parameter int BIN_W  = 14
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DIGITS*DEC_4-1:0] bcd_in,
   output logic                    busy,
   output logic                    done,
   output logic                    invalid,
   output logic [BIN_W-1:0]        bin_out
);

   localparam int BCD_W = DIGITS * DEC_4;
   localparam int CW    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   if (DEC_4 != 4) begin : g_dec_chk
      $fatal(1, "bcd_to_bin: DEC_4 must be 4");
   end

   if ((64'd1 << BIN_W) <= (64'(10 ** DIGITS) - 64'd1)) begin : g_width_chk
      $fatal(1, "bcd_to_bin: BIN_W too small to hold 10^DIGITS-1");
   end

   function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         bad = bad | (v[i*DEC_4 +: 4] > 4'd9);
      end
      return bad;
   endfunction

   function automatic logic [BCD_W-1:0] digit_correct(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      logic [3:0]       d;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[i*DEC_4 +: 4];
         r[i*DEC_4 +: 4] = (d >= 4'd8) ? (d - 4'd3) : d;
      end
      return r;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BIN_W-1:0] bin_out_q, bin_out_d;
   logic             invalid_q, invalid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [BCD_W-1:0] shifted_bcd_s;
   logic [BIN_W-1:0] shifted_bin_s;

   // Next-state logic: accept requests in IDLE/DONE, run one shift-and-correct step per SHIFT cycle.
   always_comb begin
      state_d       = state_q;
      bcd_d         = bcd_q;
      bin_d         = bin_q;
      cnt_d         = cnt_q;
      bin_out_d     = bin_out_q;
      invalid_d     = invalid_q;
      shifted_bcd_s = digit_correct({1'b0, bcd_q[BCD_W-1:1]});
      shifted_bin_s = {bcd_q[0], bin_q[BIN_W-1:1]};
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (has_bad_digit(bcd_in)) begin
                  state_d   = S_DONE;
                  invalid_d = 1'b1;
                  bin_out_d = {BIN_W{1'b0}};
               end else begin
                  state_d   = S_SHIFT;
                  bcd_d     = bcd_in;
                  bin_d     = {BIN_W{1'b0}};
                  cnt_d     = {CW{1'b0}};
                  invalid_d = 1'b0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            bcd_d = shifted_bcd_s;
            bin_d = shifted_bin_s;
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_LAST) begin
               bin_out_d = shifted_bin_s;
               state_d   = S_DONE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_SHIFT);
      done_d = (state_d == S_DONE);
   end

   // State, work register and registered outputs; reset aborts any conversion in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         bcd_q     <= {BCD_W{1'b0}};
         bin_q     <= {BIN_W{1'b0}};
         cnt_q     <= {CW{1'b0}};
         bin_out_q <= {BIN_W{1'b0}};
         invalid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcd_q     <= bcd_d;
         bin_q     <= bin_d;
         cnt_q     <= cnt_d;
         bin_out_q <= bin_out_d;
         invalid_q <= invalid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign invalid = invalid_q;
   assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed and table-driven bench for bcd_to_bin; expected values are decimal hand computations.
module tb_bcd_to_bin;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] bcd_in;
   logic        busy;
   logic        done;
   logic        invalid;
   logic [13:0] bin_out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] bcd;
      logic [13:0] exp_bin;
      logic        exp_inv;
      int          exp_lat;
      int          exp_busy;
   } vec_t;

   vec_t vecs[8];

   bcd_to_bin #(.DIGITS(4), .DEC_4(4), .BIN_W(14)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .invalid (invalid),
      .bin_out (bin_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // lat counts clock edges after the accepting edge until done is seen; bc counts busy cycles
   task automatic wait_done(input int lat0, input int bc0, output int lat, output int bc);
      lat = lat0;
      bc  = bc0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_conv(input logic [15:0] bcd, output int lat, output int bc,
                           output logic [13:0] res, output logic inv);
      start  = 1'b1;
      bcd_in = bcd;
      @(negedge clk);
      start  = 1'b0;
      wait_done(0, 0, lat, bc);
      res = bin_out;
      inv = invalid;
   endtask

   initial begin
      int          lat;
      int          bc;
      logic [13:0] res;
      logic        inv;
      logic [15:0] op;

      vecs[0] = '{16'h1234, 14'd1234, 1'b0, 14, 14};
      vecs[1] = '{16'h9999, 14'd9999, 1'b0, 14, 14};
      vecs[2] = '{16'h0000, 14'd0,    1'b0, 14, 14};
      vecs[3] = '{16'h12A4, 14'd0,    1'b1, 0,  0};
      vecs[4] = '{16'h0809, 14'd809,  1'b0, 14, 14};
      vecs[5] = '{16'hF000, 14'd0,    1'b1, 0,  0};
      vecs[6] = '{16'h8008, 14'd8008, 1'b0, 14, 14};
      vecs[7] = '{16'h0010, 14'd10,   1'b0, 14, 14};

      rst    = 1'b0;
      start  = 1'b0;
      bcd_in = 16'h0000;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_invalid", 32'(invalid), 32'd0);
      check("reset_bin_out", 32'(bin_out), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_conv(vecs[i].bcd, lat, bc, res, inv);
         check($sformatf("vec%0d_bin", i), 32'(res), 32'(vecs[i].exp_bin));
         check($sformatf("vec%0d_invalid", i), 32'(inv), 32'(vecs[i].exp_inv));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].exp_busy));
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
         check($sformatf("vec%0d_bin_hold", i), 32'(bin_out), 32'(vecs[i].exp_bin));
      end

      // start pulsed mid-conversion must be ignored; operand change must not matter
      start  = 1'b1;
      bcd_in = 16'h0500;
      @(negedge clk);
      start = 1'b0;
      bc    = 0;
      for (int i = 0; i < 5; i++) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
      end
      start  = 1'b1;
      bcd_in = 16'h0001;
      if (busy === 1'b1) bc++;
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 16'h9999;
      wait_done(6, bc, lat, bc);
      check("ignore_start_bin", 32'(bin_out), 32'd500);
      check("ignore_start_latency", 32'(lat), 32'd14);
      check("ignore_start_busy_cycles", 32'(bc), 32'd14);

      // back-to-back request issued in the DONE cycle
      run_conv(16'h0001, lat, bc, res, inv);
      check("b2b_bin", 32'(res), 32'd1);
      check("b2b_latency", 32'(lat), 32'd14);
      check("b2b_busy_cycles", 32'(bc), 32'd14);
      @(negedge clk);

      // asynchronous reset in the middle of a conversion
      start  = 1'b1;
      bcd_in = 16'h0777;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      check("pre_reset_busy", 32'(busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      check("async_rst_invalid", 32'(invalid), 32'd0);
      check("async_rst_bin_out", 32'(bin_out), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_conv(16'h0042, lat, bc, res, inv);
      check("post_rst_bin", 32'(res), 32'd42);
      check("post_rst_latency", 32'(lat), 32'd14);
      @(negedge clk);

      // strided sweep of valid operands, chained back-to-back through the DONE cycle
      for (int v = 0; v < 10000; v += 7) begin
         op = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
         run_conv(op, lat, bc, res, inv);
         check($sformatf("sweep_%0d", v),
               {1'b0, inv, 16'(lat), 14'(res)},
               {1'b0, 1'b0, 16'd14, 14'(v)});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
